// File: rtl/giga_im_loader.sv
// Boot-time instruction-memory loader: consumes a length-prefixed byte stream,
// assembles big-endian 32-bit words and holds the core in reset until loaded.
module giga_im_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_d,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t              state;
  state_t              next_state;
  logic [7:0]          len_hi_q;
  logic [15:0]         len_q;
  logic [15:0]         len_next;
  logic [1:0]          byte_idx;
  logic [23:0]         word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     wl_inc;
  logic                last_word;
  logic                accept;

  function automatic logic len_exceeds(input logic [15:0] n);
    return {1'b0, n} > DEPTH_W;
  endfunction

  // in_ready is a registered decode of the state, so accept is glitch-free
  assign accept    = in_valid & in_ready;
  assign len_next  = {len_hi_q, in_data};
  assign wl_inc    = words_loaded + 1'b1;
  assign last_word = (16'(wl_inc) == len_q);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_state = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if (len_next == 16'd0)         next_state = S_DONE;
          else if (len_exceeds(len_next)) next_state = S_ERR;
          else                           next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_idx == 2'd3) next_state = S_WRITE;
      end
      S_WRITE: begin
        next_state = last_word ? S_DONE : S_DATA;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Control outputs are registered from next_state so they align with state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                  (next_state == S_DATA);
      im_we    <= (next_state == S_WRITE);
      busy     <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                  (next_state == S_DATA)   || (next_state == S_WRITE);
      done     <= (next_state == S_DONE);
      err      <= (next_state == S_ERR);
      core_rst <= (next_state != S_DONE);
    end
  end

  // Header capture, word assembly and address/count bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_q     <= '0;
      len_q        <= '0;
      byte_idx     <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      im_addr      <= '0;
      im_d         <= '0;
      words_loaded <= '0;
    end else begin
      if (state == S_LEN_HI && accept) begin
        len_hi_q <= in_data;
      end
      if (state == S_LEN_LO && accept) begin
        len_q        <= len_next;
        words_loaded <= '0;
        byte_idx     <= '0;
        addr_q       <= '0;
        im_addr      <= '0;
      end
      if (state == S_DATA && accept) begin
        word_q   <= {word_q[15:0], in_data};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          im_d    <= {word_q, in_data};
          im_addr <= addr_q;
        end
      end
      // Pointer stops at the final address so it never leaves 0..DEPTH-1
      if (state == S_WRITE) begin
        words_loaded <= wl_inc;
        byte_idx     <= '0;
        if (!last_word) addr_q <= addr_q + 1'b1;
      end
    end
  end

endmodule
